// File: rtl/softmax_pkg.sv
// Shared types and widths for the LSTM softmax anomaly stage.
package softmax_pkg;
  localparam logic        SYS_TYPE = 1'b1;
  localparam logic        BR_TYPE  = 1'b0;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ACC_W    = 24;
  localparam int unsigned BIAS_W   = 16;
  localparam int unsigned PSUM_W   = 19;

  typedef enum logic {IDLE, COMPUTE} state_e;
endpackage

// File: rtl/softmax_unit_mac8.sv
// Eight signed int8 x int8 products reduced by a balanced adder tree (combinational).
module mac8
  import softmax_pkg::*;
(
  input  logic [8*DATA_W-1:0]      i_w,
  input  logic [8*DATA_W-1:0]      i_h,
  output logic signed [PSUM_W-1:0] o_psum
);
  logic signed [2*DATA_W-1:0] w_prod [8];
  logic signed [2*DATA_W:0]   w_s1   [4];
  logic signed [2*DATA_W+1:0] w_s2   [2];

  always_comb begin
    for (int unsigned j = 0; j < 8; j++) begin
      w_prod[j] = $signed({{DATA_W{i_w[j*DATA_W+DATA_W-1]}}, i_w[j*DATA_W +: DATA_W]}) *
                  $signed({{DATA_W{i_h[j*DATA_W+DATA_W-1]}}, i_h[j*DATA_W +: DATA_W]});
    end
    for (int unsigned j = 0; j < 4; j++) begin
      w_s1[j] = {w_prod[2*j][2*DATA_W-1], w_prod[2*j]} +
                {w_prod[2*j+1][2*DATA_W-1], w_prod[2*j+1]};
    end
    for (int unsigned j = 0; j < 2; j++) begin
      w_s2[j] = {w_s1[2*j][2*DATA_W], w_s1[2*j]} + {w_s1[2*j+1][2*DATA_W], w_s1[2*j+1]};
    end
    o_psum = {w_s2[0][2*DATA_W+1], w_s2[0]} + {w_s2[1][2*DATA_W+1], w_s2[1]};
  end
endmodule

// File: rtl/softmax_unit.sv
// LSTM output stage: per-class logits from the latched hidden state, max-normalised
// log-softmax check of observed trace events, one-cycle oAbnormal pulse on improbable events.
module softmax_unit
  import softmax_pkg::*;
#(
  parameter int unsigned NUM_CLASS  = 16,
  parameter int unsigned CLASS_BITS = 4,
  parameter int          THRESH     = 49152,
  parameter string       SYS_W_FILE = "",
  parameter string       SYS_B_FILE = "",
  parameter string       BR_W_FILE  = "",
  parameter string       BR_B_FILE  = ""
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         iLstm_valid,
  input  logic         iLstm_type,
  input  logic [63:0]  iSys_Ht,
  input  logic [511:0] iBr_Ht,
  input  logic         iFIFO_valid,
  input  logic [12:0]  iFIFO_data,
  output logic         oAbnormal
);
  localparam int unsigned CNT_W = CLASS_BITS + 3;
  localparam logic signed [ACC_W-1:0] THRESH_Q = ACC_W'(THRESH);

  logic [DATA_W-1:0] r_sys_w [NUM_CLASS*8];
  logic [DATA_W-1:0] r_br_w  [NUM_CLASS*64];
  logic [BIAS_W-1:0] r_sys_b [NUM_CLASS];
  logic [BIAS_W-1:0] r_br_b  [NUM_CLASS];

  initial begin
    for (int unsigned i = 0; i < NUM_CLASS*8; i++)  r_sys_w[i] = '0;
    for (int unsigned i = 0; i < NUM_CLASS*64; i++) r_br_w[i]  = '0;
    for (int unsigned i = 0; i < NUM_CLASS; i++)    r_sys_b[i] = '0;
    for (int unsigned i = 0; i < NUM_CLASS; i++)    r_br_b[i]  = '0;
  end

  state_e                   r_state, w_state_next;
  logic                     r_type;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_W-1:0]        r_sys_ht [8];
  logic [DATA_W-1:0]        r_br_ht  [64];
  logic signed [ACC_W-1:0]  r_acc, r_run_max;
  logic signed [ACC_W-1:0]  r_logit [2][NUM_CLASS];
  logic signed [ACC_W-1:0]  r_max   [2];
  logic [1:0]               r_valid;
  logic                     r_pend, r_pend_type;
  logic [CLASS_BITS-1:0]    r_pend_cls;

  logic [CLASS_BITS-1:0]    w_cls;
  logic [2:0]               w_chunk;
  logic                     w_first, w_last, w_done;
  logic [8*DATA_W-1:0]      w_wvec, w_hvec;
  logic signed [PSUM_W-1:0] w_psum;
  logic [BIAS_W-1:0]        w_bias;
  logic signed [ACC_W-1:0]  w_sum, w_logit, w_new_max, w_diff_ev, w_diff_pend;
  logic                     w_ev_type, w_cap_same, w_busy, w_ev_pend, w_ev_now, w_pend_now;
  logic [CLASS_BITS-1:0]    w_ev_cls;
  logic                     w_unused;

  assign w_unused = ^iFIFO_data[11:CLASS_BITS];

  // BR walks 8 chunks of 8 lanes per class; SYS finishes a class every cycle.
  assign w_chunk = (r_type == BR_TYPE) ? r_cnt[2:0] : 3'd0;
  assign w_cls   = (r_type == BR_TYPE) ? r_cnt[CNT_W-1:3] : r_cnt[CLASS_BITS-1:0];
  assign w_first = (w_chunk == 3'd0);
  assign w_last  = (r_type == SYS_TYPE) || (w_chunk == 3'd7);
  assign w_done  = (r_state == COMPUTE) && w_last && (w_cls == CLASS_BITS'(NUM_CLASS-1));

  always_comb begin
    w_wvec = '0;
    w_hvec = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      if (r_type == SYS_TYPE) begin
        w_wvec[j*DATA_W +: DATA_W] = r_sys_w[{w_cls, 3'(j)}];
        w_hvec[j*DATA_W +: DATA_W] = r_sys_ht[j];
      end else begin
        w_wvec[j*DATA_W +: DATA_W] = r_br_w[{w_cls, w_chunk, 3'(j)}];
        w_hvec[j*DATA_W +: DATA_W] = r_br_ht[{w_chunk, 3'(j)}];
      end
    end
  end

  mac8 u_mac8 (
    .i_w    (w_wvec),
    .i_h    (w_hvec),
    .o_psum (w_psum)
  );

  always_comb begin
    w_bias    = (r_type == SYS_TYPE) ? r_sys_b[w_cls] : r_br_b[w_cls];
    w_sum     = (w_first ? '0 : r_acc) + {{(ACC_W-PSUM_W){w_psum[PSUM_W-1]}}, w_psum};
    w_logit   = w_sum + {{(ACC_W-BIAS_W){w_bias[BIAS_W-1]}}, w_bias};
    w_new_max = ((w_cls == '0) || (w_logit > r_run_max)) ? w_logit : r_run_max;
  end

  assign w_ev_type  = iFIFO_data[12];
  assign w_ev_cls   = iFIFO_data[CLASS_BITS-1:0];
  assign w_cap_same = iLstm_valid && (iLstm_type == w_ev_type);
  assign w_busy     = (r_state == COMPUTE) && (r_type == w_ev_type);
  assign w_ev_pend  = iFIFO_valid && (w_cap_same || w_busy);
  assign w_ev_now   = iFIFO_valid && !w_cap_same && !w_busy && r_valid[w_ev_type];
  assign w_pend_now = r_pend && r_valid[r_pend_type];
  assign w_diff_ev   = r_max[w_ev_type] - r_logit[w_ev_type][w_ev_cls];
  assign w_diff_pend = r_max[r_pend_type] - r_logit[r_pend_type][r_pend_cls];

  always_comb begin
    w_state_next = r_state;
    if (iLstm_valid)  w_state_next = COMPUTE;
    else if (w_done)  w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (resetn) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      oAbnormal   <= 1'b0;
      r_type      <= BR_TYPE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_run_max   <= '0;
      r_valid     <= '0;
      r_pend      <= 1'b0;
      r_pend_type <= BR_TYPE;
      r_pend_cls  <= '0;
      for (int unsigned i = 0; i < 8; i++)  r_sys_ht[i] <= '0;
      for (int unsigned i = 0; i < 64; i++) r_br_ht[i]  <= '0;
      for (int unsigned t = 0; t < 2; t++) begin
        r_max[t] <= '0;
        for (int unsigned c = 0; c < NUM_CLASS; c++) r_logit[t][c] <= '0;
      end
    end else begin
      oAbnormal <= (w_ev_now && (w_diff_ev > THRESH_Q)) ||
                   (w_pend_now && (w_diff_pend > THRESH_Q));

      // A new Ht always restarts, so an interrupted type keeps its flag cleared.
      if (iLstm_valid) begin
        r_type              <= iLstm_type;
        r_cnt               <= '0;
        r_valid[iLstm_type] <= 1'b0;
        if (iLstm_type == SYS_TYPE) begin
          for (int unsigned i = 0; i < 8; i++)
            r_sys_ht[i] <= iSys_Ht[(7-i)*DATA_W +: DATA_W];
        end else begin
          for (int unsigned i = 0; i < 64; i++)
            r_br_ht[i] <= iBr_Ht[(63-i)*DATA_W +: DATA_W];
        end
      end else if (r_state == COMPUTE) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_sum;
        if (w_last) begin
          r_logit[r_type][w_cls] <= w_logit;
          r_run_max              <= w_new_max;
        end
        if (w_done) begin
          r_max[r_type]   <= w_new_max;
          r_valid[r_type] <= 1'b1;
        end
      end

      if (w_ev_pend) begin
        r_pend      <= 1'b1;
        r_pend_type <= w_ev_type;
        r_pend_cls  <= w_ev_cls;
      end else if (w_pend_now) begin
        r_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_softmax_unit.sv
// Directed bench for softmax_unit: ROM contents are written hierarchically before each scenario.
module tb_softmax_unit;
  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         iLstm_valid = 1'b0;
  logic         iLstm_type = 1'b0;
  logic [63:0]  iSys_Ht = '0;
  logic [511:0] iBr_Ht = '0;
  logic         iFIFO_valid = 1'b0;
  logic [12:0]  iFIFO_data = '0;
  logic         oAbnormal;

  int unsigned cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  softmax_unit #(.NUM_CLASS(16), .CLASS_BITS(4), .THRESH(49152)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iLstm_valid (iLstm_valid),
    .iLstm_type  (iLstm_type),
    .iSys_Ht     (iSys_Ht),
    .iBr_Ht      (iBr_Ht),
    .iFIFO_valid (iFIFO_valid),
    .iFIFO_data  (iFIFO_data),
    .oAbnormal   (oAbnormal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic typ, input logic [7:0] byte_val, output int edge_no);
    iLstm_valid = 1'b1;
    iLstm_type  = typ;
    iSys_Ht     = {8{byte_val}};
    iBr_Ht      = {64{byte_val}};
    tick();
    iLstm_valid = 1'b0;
    edge_no = int'(cyc);
  endtask

  task automatic send_fifo(input logic [12:0] data);
    iFIFO_valid = 1'b1;
    iFIFO_data  = data;
    tick();
    iFIFO_valid = 1'b0;
  endtask

  task automatic watch(input int n, output int pulses, output int first_edge);
    pulses = 0;
    first_edge = -1;
    repeat (n) begin
      tick();
      if (oAbnormal === 1'b1) begin
        if (pulses == 0) first_edge = int'(cyc);
        pulses++;
      end
    end
  endtask

  task automatic clear_sys_rom();
    for (int i = 0; i < 128; i++) dut.r_sys_w[i] = 8'h00;
    for (int i = 0; i < 16; i++)  dut.r_sys_b[i] = 16'h0000;
  endtask

  task automatic clear_br_rom();
    for (int i = 0; i < 1024; i++) dut.r_br_w[i] = 8'h00;
    for (int i = 0; i < 16; i++)   dut.r_br_b[i] = 16'h0000;
  endtask

  task automatic test_reset();
    int p, f;
    resetn = 1'b1;
    repeat (3) tick();
    resetn = 1'b0;
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL reset_out: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    send_fifo(13'h1000);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL no_ht_event: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    watch(3, p, f);
    n_total++;
    if (p !== 0) $display("FAIL no_ht_quiet: pulses=%0d expected 0", p);
    else n_pass++;
  endtask

  // L[0]=32767, L[1]=-32768, rest 0 -> max 32767
  task automatic test_sys();
    int e, p, f;
    clear_sys_rom();
    dut.r_sys_b[0] = 16'h7FFF;
    dut.r_sys_b[1] = 16'h8000;
    capture(1'b1, 8'h80, e);
    watch(20, p, f);
    n_total++;
    if (p !== 0) $display("FAIL sys_compute_quiet: pulses=%0d expected 0", p);
    else n_pass++;
    send_fifo(13'h1000);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL sys_class0: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    send_fifo(13'h1001);
    n_total++;
    if (oAbnormal !== 1'b1) $display("FAIL sys_class1: oAbnormal=%0b expected 1", oAbnormal);
    else n_pass++;
    tick();
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL sys_one_cycle: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
  endtask

  // L[2] = 64 * (127 * -128) = -1040384, rest 0
  task automatic test_br();
    int e, p, f;
    clear_br_rom();
    for (int i = 0; i < 64; i++) dut.r_br_w[2*64 + i] = 8'h7F;
    capture(1'b0, 8'h80, e);
    watch(130, p, f);
    n_total++;
    if (p !== 0) $display("FAIL br_compute_quiet: pulses=%0d expected 0", p);
    else n_pass++;
    send_fifo(13'h0002);
    n_total++;
    if (oAbnormal !== 1'b1) $display("FAIL br_class2: oAbnormal=%0b expected 1", oAbnormal);
    else n_pass++;
    tick();
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL br_one_cycle: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    send_fifo(13'h0000);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL br_class0: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
  endtask

  task automatic test_cross_type();
    int e, p, f;
    capture(1'b1, 8'h80, e);
    send_fifo(13'h0002);
    n_total++;
    if (oAbnormal !== 1'b1) $display("FAIL cross_br_during_sys: oAbnormal=%0b expected 1", oAbnormal);
    else n_pass++;
    watch(20, p, f);
    n_total++;
    if (p !== 0) $display("FAIL cross_after: pulses=%0d expected 0", p);
    else n_pass++;
  endtask

  task automatic test_pending();
    int c0, p, f;
    capture(1'b0, 8'h80, c0);
    send_fifo(13'h0002);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL pend_at_send: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    watch(130, p, f);
    n_total++;
    if (p !== 1) $display("FAIL pend_count: pulses=%0d expected 1", p);
    else n_pass++;
    n_total++;
    if (f !== c0 + 129) $display("FAIL pend_timing: pulse edge=%0d expected %0d", f, c0 + 129);
    else n_pass++;
  endtask

  // max=24576; class1 diff exactly 49152 (tie), class2 diff 49153
  task automatic test_threshold();
    int e, p, f;
    clear_sys_rom();
    dut.r_sys_b[0] = 16'h6000;
    dut.r_sys_b[1] = 16'hA000;
    dut.r_sys_b[2] = 16'h9FFF;
    capture(1'b1, 8'h55, e);
    watch(18, p, f);
    n_total++;
    if (p !== 0) $display("FAIL thr_quiet: pulses=%0d expected 0", p);
    else n_pass++;
    send_fifo(13'h1001);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL thr_tie: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    send_fifo(13'h1002);
    n_total++;
    if (oAbnormal !== 1'b1) $display("FAIL thr_above: oAbnormal=%0b expected 1", oAbnormal);
    else n_pass++;
    send_fifo(13'h1000);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL thr_max_class: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
  endtask

  // Second Ht 8x7F gives L[1]=129032 (max); first Ht 8x80 would give L[1]=-130048
  task automatic test_restart();
    int a, b, p, f;
    clear_sys_rom();
    for (int j = 0; j < 8; j++) dut.r_sys_w[8 + j] = 8'h7F;
    capture(1'b1, 8'h80, a);
    repeat (4) tick();
    capture(1'b1, 8'h7F, b);
    send_fifo(13'h1000);
    watch(19, p, f);
    n_total++;
    if (p !== 1) $display("FAIL restart_count: pulses=%0d expected 1", p);
    else n_pass++;
    n_total++;
    if (f !== b + 17) $display("FAIL restart_timing: pulse edge=%0d expected %0d", f, b + 17);
    else n_pass++;
    send_fifo(13'h1001);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL restart_class1: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    send_fifo(13'h1002);
    n_total++;
    if (oAbnormal !== 1'b1) $display("FAIL restart_class2: oAbnormal=%0b expected 1", oAbnormal);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c, p, f;
    capture(1'b0, 8'h80, c);
    watch(50, p, f);
    n_total++;
    if (p !== 0) $display("FAIL rmid_before: pulses=%0d expected 0", p);
    else n_pass++;
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL rmid_out: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    send_fifo(13'h0002);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL rmid_br_event: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    send_fifo(13'h1002);
    n_total++;
    if (oAbnormal !== 1'b0) $display("FAIL rmid_sys_event: oAbnormal=%0b expected 0", oAbnormal);
    else n_pass++;
    watch(140, p, f);
    n_total++;
    if (p !== 0) $display("FAIL rmid_after: pulses=%0d expected 0", p);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sys();
    test_br();
    test_cross_type();
    test_pending();
    test_threshold();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
